// File: rtl/dmem_pkg.sv
// Shared constants for dmem_ctrl and its storage array: FSM encodings,
// zero fill, byte-lane count helper and legal read-latency bounds.
package dmem_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Replicated to any DATA_W as {DATA_W{WORD_ZERO}}.
    localparam logic WORD_ZERO = 1'b0;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;
    localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX);

    function automatic int unsigned lane_cnt(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-strobed synchronous write and a registered read
// captured only when re is asserted. Contents are never cleared.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic                          re,
    input  logic [DEPTH_LOG2-1:0]         addr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [lane_cnt(DATA_W)-1:0]   wstrb,
    output logic [DATA_W-1:0]             rdata
);

    localparam int unsigned LANES = lane_cnt(DATA_W);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= {DATA_W{WORD_ZERO}};
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request/response, RD_LAT-cycle read
// latency, range check; DMEM_ALIGN_CHECK_EN adds a word-alignment check.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [31:0]                   req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [lane_cnt(DATA_W)-1:0]   req_wstrb,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_err
);

    dmem_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic rd_ok_q, rd_ok_d;
    logic hs, acc_err, range_err, align_err;
    logic arr_we, arr_re;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [DATA_W-1:0] arr_rdata;

    assign word_idx  = req_addr[DEPTH_LOG2+1:2];
    assign range_err = (req_addr >> (DEPTH_LOG2 + 2)) != '0;

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = req_addr[1:0] != 2'b00;
`else
    logic unused_addr_lsb;
    assign align_err       = 1'b0;
    assign unused_addr_lsb = ^req_addr[1:0];
`endif

    assign acc_err = range_err | align_err;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rd_ok_d    = rd_ok_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        hs         = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                req_ready = ~rst;
                if (req_valid && !rst) begin
                    hs      = 1'b1;
                    err_d   = acc_err;
                    rd_ok_d = ~req_write & ~acc_err;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = (RD_LAT == 1) ? DMEM_RESP : DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DMEM_RESP;
            end
            DMEM_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    // Storage is touched only at the handshake edge; the array's read register
    // then holds the response data until the next accepted read.
    assign arr_we = hs & req_write & ~acc_err;
    assign arr_re = hs & ~req_write;

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (word_idx),
        .wdata (req_wdata),
        .wstrb (req_wstrb),
        .rdata (arr_rdata)
    );

    assign resp_rdata = (resp_valid && rd_ok_q) ? arr_rdata : {DATA_W{WORD_ZERO}};
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (RD_LAT=1 and RD_LAT=4) driven by a vector
// table, hand-written reset/backpressure sequences and random traffic.
module tb_dmem_ctrl;

    localparam int unsigned DW   = 32;
    localparam int unsigned DL   = 16;
    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 4;
    localparam int unsigned WIN  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_write [2];
    logic        resp_ready[2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        req_ready [2];
    logic        resp_valid[2];
    logic        resp_err  [2];
    logic [31:0] resp_rdata[2];

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [2][WIN];

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [14];

    dmem_ctrl #(.DATA_W(DW), .DEPTH_LOG2(DL), .RD_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_ctrl #(.DATA_W(DW), .DEPTH_LOG2(DL), .RD_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    // Expected error flag straight from the access rules.
    function automatic logic exp_err_of(input logic [31:0] a);
        logic e;
        e = (a >> (DL + 2)) != 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
        e = e | (a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_req(input int d, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
        req_wdata[d] = data; req_wstrb[d] = strb;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    // Full transaction; while busy, a junk write is kept on req_* and must be ignored.
    task automatic do_access(input int d, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input int hold, input logic early_rdy, input string tag,
                             output logic [31:0] rdata, output logic err);
        int lat;
        rdata = '0;
        err   = 1'b0;
        @(negedge clk);
        chk($sformatf("%s req_ready_idle", tag), 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
        req_wdata[d] = data; req_wstrb[d] = strb;
        @(posedge clk);
        @(negedge clk);
        req_write[d]  = 1'b1;
        req_addr[d]   = {25'd0, 5'($urandom_range(0, WIN - 1)), 2'b00};
        req_wdata[d]  = $urandom;
        req_wstrb[d]  = 4'hF;
        resp_ready[d] = early_rdy;
        lat = 1;
        while (!resp_valid[d] && lat <= 20) begin
            chk($sformatf("%s req_ready_busy", tag), 32'(req_ready[d]), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s latency", tag), 32'(lat), 32'(lat_of(d)));
        if (!resp_valid[d]) begin
            req_valid[d]  = 1'b0;
            resp_ready[d] = 1'b0;
            return;
        end
        rdata = resp_rdata[d];
        err   = resp_err[d];
        if (!early_rdy) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk($sformatf("%s hold_valid", tag), 32'(resp_valid[d]), 32'd1);
                chk($sformatf("%s hold_req_ready", tag), 32'(req_ready[d]), 32'd0);
                chk($sformatf("%s hold_rdata", tag), resp_rdata[d], rdata);
                chk($sformatf("%s hold_err", tag), 32'(resp_err[d]), 32'(err));
            end
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk($sformatf("%s resp_done", tag), 32'(resp_valid[d]), 32'd0);
        chk($sformatf("%s req_ready_after", tag), 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a, dat, exp_rd;
        logic [3:0]  st;
        logic        wr, ee;
        int unsigned w;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; resp_ready[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; req_wstrb[d] = '0;
        end

        tbl[0]  = '{1'b1, 32'h0000_0008, 32'h0000_FFFF, 4'hF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h0000_FFFF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_002C, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_002C, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_002C, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        tbl[6]  = '{1'b1, 32'h0004_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1};
        tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_002C, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_002C, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        tbl[10] = '{1'b0, 32'h0004_0000, 32'h0,         4'h0, 32'h0, 1'b1};
        tbl[11] = '{1'b1, 32'h0000_0004, 32'h0102_0304, 4'hF, 32'h0, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        tbl[12] = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 32'h0, 1'b1};
`else
        tbl[12] = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 32'h0102_0304, 1'b0};
`endif
        tbl[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d resp_valid", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("rst%0d req_ready", d),  32'(req_ready[d]),  32'd0);
            chk($sformatf("rst%0d resp_rdata", d), resp_rdata[d],      32'd0);
            chk($sformatf("rst%0d resp_err", d),   32'(resp_err[d]),   32'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("rst%0d req_ready_release", d), 32'(req_ready[d]), 32'd1);

        for (int i = 0; i < 14; i++) begin
            do_access(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb,
                      i % 3, (i == 4), $sformatf("vec%0d", i), rd, er);
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // RD_LAT=4: backpressure for 5 cycles, then resp_ready held through WAIT.
        do_access(1, 1'b1, 32'h10, 32'h5A5A_1234, 4'hF, 0, 1'b0, "l4_wr", rd, er);
        do_access(1, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, "l4_rd", rd, er);
        chk("l4_rd rdata", rd, 32'h5A5A_1234);
        chk("l4_rd err", 32'(er), 32'd0);
        do_access(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, "l4_early", rd, er);
        chk("l4_early rdata", rd, 32'h5A5A_1234);

        // Reset mid-WAIT after a write handshake: response dropped, write kept.
        start_req(1, 1'b1, 32'h14, 32'h0BAD_CAFE, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwait resp_valid", 32'(resp_valid[1]), 32'd0);
        chk("rstwait req_ready_in_rst", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstwait req_ready", 32'(req_ready[1]), 32'd1);
        repeat (6) @(negedge clk);
        chk("rstwait no_resp", 32'(resp_valid[1]), 32'd0);
        do_access(1, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0, "rstwait_rb", rd, er);
        chk("rstwait_rb rdata", rd, 32'h0BAD_CAFE);

        // Reset while the response is being held.
        start_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("rstresp valid_before", 32'(resp_valid[1]), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstresp resp_valid", 32'(resp_valid[1]), 32'd0);
        chk("rstresp resp_rdata", resp_rdata[1], 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against a word-array model of the access rules.
        for (int d = 0; d < 2; d++) begin
            for (int unsigned k = 0; k < WIN; k++) begin
                dat = $urandom;
                do_access(d, 1'b1, k * 4, dat, 4'hF, 0, 1'b0, $sformatf("init%0d_%0d", d, k), rd, er);
                chk($sformatf("init%0d_%0d err", d, k), 32'(er), 32'd0);
                mdl[d][k] = dat;
            end
            for (int n = 0; n < 120; n++) begin
                wr  = 1'($urandom_range(0, 1));
                dat = $urandom;
                st  = 4'($urandom);
                if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0004_0000;
                else a = {25'd0, 5'($urandom_range(0, WIN - 1)), 2'($urandom)};
                w  = a[6:2];
                ee = exp_err_of(a);
                exp_rd = (!wr && !ee) ? mdl[d][w] : 32'd0;
                if (wr && !ee)
                    for (int l = 0; l < 4; l++)
                        if (st[l]) mdl[d][w][8*l +: 8] = dat[8*l +: 8];
                do_access(d, wr, a, dat, st, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
                          $sformatf("rnd%0d_%0d", d, n), rd, er);
                chk($sformatf("rnd%0d_%0d rdata a=%08h", d, n, a), rd, exp_rd);
                chk($sformatf("rnd%0d_%0d err a=%08h", d, n, a), 32'(er), 32'(ee));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory. Word-organised storage with byte-strobe writes and a valid/ready request/response handshake.
- Read latency is configurable. Out-of-range accesses are flagged.
- Sits between the datapath memory stage and storage. Lets the pipeline stall on a busy memory instead of assuming a combinational read.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH_LOG2, 16, log2 of word count; storage holds 2**DEPTH_LOG2 words.
- RD_LAT, 1, cycles from request handshake to resp_valid; legal range 1..4.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; word index = req_addr[DEPTH_LOG2+1:2].
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errored accesses.
- resp_err  out  1  access rejected.

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready=0 while rst is high, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Memory contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - Handshake occurs when req_valid & req_ready at posedge.
  - On handshake, latch op/addr/strobe/data, load counter with RD_LAT-1, then go to RESP if RD_LAT==1, else to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==1 at posedge, go to RESP.
  - Result: resp_valid rises exactly RD_LAT cycles after the handshake edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable until the handshake.
  - On resp_valid & resp_ready, return to IDLE. The next request can be accepted on the following cycle, so there is no back-to-back overlap.
  - Throughput is at most one access per RD_LAT+1 cycles.
- Write commit:
  - Storage is updated on the request handshake edge, for enabled lanes only.
  - req_wstrb=0 is legal: no change, normal response.
  - The write response carries rdata=0, err=0.
- Read:
  - Data is sampled from storage at the request handshake edge and held in the response register.
  - A later write cannot alter a pending read.
- Range check:
  - If req_addr[31:DEPTH_LOG2+2] != 0, then resp_err=1, no write occurs and rdata=0.
  - Latency is the same as for a legal access.
- resp_ready held high while in WAIT has no effect; a response only completes in RESP.
- Reset mid-operation: a pending response is dropped and the FSM returns to IDLE. A write already committed at its handshake remains in storage.
- req_* inputs are ignored whenever req_ready=0.

Optional Feature:
- DMEM_ALIGN_CHECK_EN defined: req_addr[1:0] != 0 gives resp_err=1, no write, rdata=0, normal latency. Combines OR-wise with the range check.
- DMEM_ALIGN_CHECK_EN undefined: req_addr[1:0] is ignored; the access uses the word index as normal.

Decomposition:
- Shared constants header dmem_pkg holds:
  - FSM state encodings DMEM_IDLE/DMEM_WAIT/DMEM_RESP (2 bits).
  - WORD_ZERO.
  - Byte-lane count macro DATA_W/8.
  - Legal RD_LAT bounds.
- One sub-module, dmem_array: 2**DEPTH_LOG2 x DATA_W storage, synchronous byte-strobed write, synchronous read on enable. dmem_ctrl owns the FSM, counter, range/alignment checks and response register.

Test Plan:
- Reset mid-WAIT (RD_LAT=3): issue read, assert rst one cycle later -> resp_valid drops immediately, FSM returns to IDLE, req_ready=1 after rst deasserts.
- Write then read, RD_LAT=1: write addr 0x8, data 0x0000FFFF, wstrb 4'hF -> write response err=0. Read 0x8 -> resp_valid 1 cycle after handshake with rdata 0x0000FFFF.
- Byte strobes: preload 0x11223344 at 0x2C, write 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x11BB33DD.
- Latency/backpressure, RD_LAT=4: read handshake at cycle t -> resp_valid at t+4. Hold resp_ready=0 for 5 cycles -> rdata stable, req_ready=0 throughout.
- Out-of-range: DEPTH_LOG2=16, write to 0x0004_0000 -> err=1; then read 0x0 -> original value unchanged.
- Alignment (DMEM_ALIGN_CHECK_EN defined): read 0x0000_0006 -> err=1, rdata=0. Same stimulus with the macro undefined -> err=0, word 1 returned.
